// File: rtl/alarm_controller.sv
// Alarm sequencer: detects the onset of a time match against the programmed
// alarm, then runs the ring / snooze / stop / auto-stop behaviour and drives
// the buzzer with a 1 Hz beep pattern.
module alarm_controller #(
    parameter int SNOOZE_SEC       = 300,
    parameter int RING_TIMEOUT_SEC = 60,
    parameter int MAX_SNOOZE       = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic [4:0] cur_hours,
    input  logic [5:0] cur_minutes,
    input  logic [5:0] cur_seconds,
    input  logic [4:0] alarm_hours,
    input  logic [5:0] alarm_minutes,
    input  logic [5:0] alarm_seconds,
    input  logic       alarm_enable,
    input  logic       alarm_mode,
    input  logic       snooze_btn,
    input  logic       stop_btn,
    output logic       buzzer,
    output logic       ringing,
    output logic       snoozing,
    output logic [1:0] state,
    output logic [3:0] snooze_count
);

    // Counters only ever reach PARAM-1, so $clog2 bits suffice; keep at least 1 bit.
    localparam int RING_W = (RING_TIMEOUT_SEC > 1) ? $clog2(RING_TIMEOUT_SEC) : 1;
    localparam int SNZ_W  = (SNOOZE_SEC > 1) ? $clog2(SNOOZE_SEC) : 1;
    localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_TIMEOUT_SEC - 1);
    localparam logic [SNZ_W-1:0]  SNZ_LAST  = SNZ_W'(SNOOZE_SEC - 1);
    localparam logic [3:0]        SNZ_MAX   = 4'(MAX_SNOOZE);

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        RINGING  = 2'd2,
        SNOOZE   = 2'd3
    } state_t;

    state_t              state_reg, state_next;
    logic [RING_W-1:0]   ring_cnt_reg, ring_cnt_next;
    logic [SNZ_W-1:0]    snooze_cnt_reg, snooze_cnt_next;
    logic [3:0]          snooze_count_reg, snooze_count_next;
    logic                beep_reg, beep_next;
    logic                buzzer_reg, ringing_reg, snoozing_reg;
    logic                match_d_reg, snooze_prev_reg, stop_prev_reg;

    logic match, trigger, snooze_press, stop_press;

    // Match and edge detection; trigger fires only on the match onset.
    assign match        = (cur_hours == alarm_hours) && (cur_minutes == alarm_minutes)
                          && (cur_seconds == alarm_seconds);
    assign trigger      = match && !match_d_reg && !alarm_mode;
    assign snooze_press = snooze_btn && !snooze_prev_reg;
    assign stop_press   = stop_btn && !stop_prev_reg;

    // Next-state and counter logic; stop beats snooze beats tick/trigger.
    always_comb begin
        state_next        = state_reg;
        ring_cnt_next     = ring_cnt_reg;
        snooze_cnt_next   = snooze_cnt_reg;
        snooze_count_next = snooze_count_reg;
        beep_next         = beep_reg;

        if (!alarm_enable) begin
            state_next        = DISARMED;
            ring_cnt_next     = '0;
            snooze_cnt_next   = '0;
            snooze_count_next = '0;
            beep_next         = 1'b0;
        end else begin
            case (state_reg)
                DISARMED: state_next = ARMED;
                ARMED: begin
                    if (trigger) begin
                        state_next        = RINGING;
                        ring_cnt_next     = '0;
                        snooze_count_next = '0;
                        beep_next         = 1'b1;
                    end
                end
                RINGING: begin
                    if (stop_press) begin
                        state_next      = ARMED;
                        ring_cnt_next   = '0;
                        snooze_cnt_next = '0;
                    end else if (snooze_press && (snooze_count_reg < SNZ_MAX)) begin
                        state_next        = SNOOZE;
                        snooze_cnt_next   = '0;
                        snooze_count_next = snooze_count_reg + 4'd1;
                    end else if (tick_1hz) begin
                        if (ring_cnt_reg == RING_LAST) begin
                            state_next      = ARMED;
                            ring_cnt_next   = '0;
                            snooze_cnt_next = '0;
                        end else begin
                            ring_cnt_next = ring_cnt_reg + RING_W'(1);
                            beep_next     = !beep_reg;
                        end
                    end
                end
                SNOOZE: begin
                    if (stop_press) begin
                        state_next      = ARMED;
                        ring_cnt_next   = '0;
                        snooze_cnt_next = '0;
                    end else if (tick_1hz) begin
                        if (snooze_cnt_reg == SNZ_LAST) begin
                            state_next    = RINGING;
                            ring_cnt_next = '0;
                            beep_next     = 1'b1;
                        end else begin
                            snooze_cnt_next = snooze_cnt_reg + SNZ_W'(1);
                        end
                    end
                end
                default: state_next = DISARMED;
            endcase
        end
    end

    // State, counters, edge registers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= DISARMED;
            ring_cnt_reg     <= '0;
            snooze_cnt_reg   <= '0;
            snooze_count_reg <= '0;
            beep_reg         <= 1'b0;
            buzzer_reg       <= 1'b0;
            ringing_reg      <= 1'b0;
            snoozing_reg     <= 1'b0;
            match_d_reg      <= 1'b0;
            snooze_prev_reg  <= 1'b0;
            stop_prev_reg    <= 1'b0;
        end else begin
            state_reg        <= state_next;
            ring_cnt_reg     <= ring_cnt_next;
            snooze_cnt_reg   <= snooze_cnt_next;
            snooze_count_reg <= snooze_count_next;
            beep_reg         <= beep_next;
            buzzer_reg       <= (state_next == RINGING) && beep_next;
            ringing_reg      <= (state_next == RINGING);
            snoozing_reg     <= (state_next == SNOOZE);
            match_d_reg      <= match;
            snooze_prev_reg  <= snooze_btn;
            stop_prev_reg    <= stop_btn;
        end
    end

    assign state        = state_reg;
    assign snooze_count = snooze_count_reg;
    assign buzzer       = buzzer_reg;
    assign ringing      = ringing_reg;
    assign snoozing     = snoozing_reg;

endmodule

// File: tb/tb_alarm_controller.sv
// Bench for alarm_controller: directed scenarios checked against fixed
// expectations, then randomized traffic checked against a behavioural model.
module tb_alarm_controller;

    localparam int SN  = 3;
    localparam int TO  = 4;
    localparam int MXS = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick_1hz = 1'b0;
    logic [4:0] cur_hours = 5'd0;
    logic [5:0] cur_minutes = 6'd0;
    logic [5:0] cur_seconds = 6'd0;
    logic [4:0] alarm_hours = 5'd7;
    logic [5:0] alarm_minutes = 6'd30;
    logic [5:0] alarm_seconds = 6'd0;
    logic       alarm_enable = 1'b0;
    logic       alarm_mode = 1'b0;
    logic       snooze_btn = 1'b0;
    logic       stop_btn = 1'b0;
    logic       buzzer, ringing, snoozing;
    logic [1:0] state;
    logic [3:0] snooze_count;

    int n_checks = 0;
    int n_fails  = 0;

    alarm_controller #(.SNOOZE_SEC(SN), .RING_TIMEOUT_SEC(TO), .MAX_SNOOZE(MXS)) dut (
        .clk(clk), .reset(reset), .tick_1hz(tick_1hz),
        .cur_hours(cur_hours), .cur_minutes(cur_minutes), .cur_seconds(cur_seconds),
        .alarm_hours(alarm_hours), .alarm_minutes(alarm_minutes), .alarm_seconds(alarm_seconds),
        .alarm_enable(alarm_enable), .alarm_mode(alarm_mode),
        .snooze_btn(snooze_btn), .stop_btn(stop_btn),
        .buzzer(buzzer), .ringing(ringing), .snoozing(snoozing),
        .state(state), .snooze_count(snooze_count)
    );

    always #5 clk = ~clk;

    // Behavioural model: the alarm phase is tracked as "idle/armed/ringing/
    // snoozed", with seconds rung, seconds snoozed and snoozes used as plain ints.
    int  m_phase = 0;      // 0 off, 1 armed, 2 ringing, 3 snoozed
    int  m_rung = 0;
    int  m_snoozed = 0;
    int  m_used = 0;
    bit  m_beep = 0;
    bit  m_was_match = 0;
    bit  m_snz_was = 0;
    bit  m_stop_was = 0;

    always @(posedge clk) begin
        int  ph, rung, snzd, used;
        bit  beep, is_match, onset, snz_edge, stop_edge;
        ph = m_phase; rung = m_rung; snzd = m_snoozed; used = m_used; beep = m_beep;
        is_match  = (cur_hours == alarm_hours) && (cur_minutes == alarm_minutes)
                    && (cur_seconds == alarm_seconds);
        onset     = is_match && !m_was_match && !alarm_mode;
        snz_edge  = snooze_btn && !m_snz_was;
        stop_edge = stop_btn && !m_stop_was;
        if (reset) begin
            ph = 0; rung = 0; snzd = 0; used = 0; beep = 0;
        end else if (!alarm_enable) begin
            ph = 0; rung = 0; snzd = 0; used = 0; beep = 0;
        end else if (ph == 0) begin
            ph = 1;
        end else if (ph == 1) begin
            if (onset) begin ph = 2; rung = 0; used = 0; beep = 1; end
        end else if (stop_edge) begin
            ph = 1; rung = 0; snzd = 0;
        end else if (ph == 2) begin
            if (snz_edge && used < MXS) begin
                ph = 3; snzd = 0; used++;
            end else if (tick_1hz) begin
                rung++;
                beep = !beep;
                if (rung >= TO) begin ph = 1; rung = 0; snzd = 0; end
            end
        end else if (tick_1hz) begin
            snzd++;
            if (snzd >= SN) begin ph = 2; rung = 0; beep = 1; end
        end
        m_phase     <= ph;
        m_rung      <= rung;
        m_snoozed   <= snzd;
        m_used      <= used;
        m_beep      <= beep;
        m_was_match <= reset ? 1'b0 : is_match;
        m_snz_was   <= reset ? 1'b0 : snooze_btn;
        m_stop_was  <= reset ? 1'b0 : stop_btn;
    end

    // Inputs change just after a falling edge; one call = one rising edge.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic tick();
        tick_1hz = 1'b1; cyc();
        tick_1hz = 1'b0; cyc();
    endtask

    task automatic set_cur(input int h, input int m, input int s);
        cur_hours = 5'(h); cur_minutes = 6'(m); cur_seconds = 6'(s);
    endtask

    // Drive a fresh match onset from ARMED; leaves DUT one clk after onset.
    task automatic fire();
        set_cur(7, 29, 59); cyc();
        set_cur(7, 30, 0);  cyc();
    endtask

    task automatic test_reset();
        reset = 1'b1; cyc(); cyc();
        reset = 1'b0;
        n_checks++;
        if ({state, buzzer, ringing, snoozing, snooze_count} !== 9'd0) begin
            n_fails++;
            $display("FAIL reset_outputs: got st=%0d bz=%0d rg=%0d sz=%0d cnt=%0d want all 0",
                     state, buzzer, ringing, snoozing, snooze_count);
        end
        $display("reset: state=%0d buzzer=%0d", state, buzzer);
    endtask

    task automatic test_trigger();
        alarm_enable = 1'b1;
        set_cur(7, 29, 59); cyc();
        n_checks++;
        if (state !== 2'd1) begin n_fails++; $display("FAIL arm_state: got %0d want 1", state); end
        cyc();
        set_cur(7, 30, 0); cyc();
        n_checks++;
        if (state !== 2'd2 || buzzer !== 1'b1 || ringing !== 1'b1) begin
            n_fails++;
            $display("FAIL trigger: got st=%0d bz=%0d rg=%0d want st=2 bz=1 rg=1", state, buzzer, ringing);
        end
        tick();
        n_checks++;
        if (buzzer !== 1'b0) begin n_fails++; $display("FAIL beep_tick1: got %0d want 0", buzzer); end
        tick();
        n_checks++;
        if (buzzer !== 1'b1) begin n_fails++; $display("FAIL beep_tick2: got %0d want 1", buzzer); end
        $display("trigger: state=%0d buzzer=%0d", state, buzzer);
    endtask

    task automatic test_timeout();
        tick();
        n_checks++;
        if (state !== 2'd2 || buzzer !== 1'b0) begin
            n_fails++; $display("FAIL tick3_ring: got st=%0d bz=%0d want st=2 bz=0", state, buzzer);
        end
        tick_1hz = 1'b1; cyc(); tick_1hz = 1'b0;
        n_checks++;
        if (state !== 2'd1 || buzzer !== 1'b0 || ringing !== 1'b0) begin
            n_fails++; $display("FAIL timeout: got st=%0d bz=%0d want st=1 bz=0", state, buzzer);
        end
        repeat (6) cyc();
        n_checks++;
        if (state !== 2'd1) begin n_fails++; $display("FAIL no_retrigger: got %0d want 1", state); end
        $display("timeout: state=%0d buzzer=%0d", state, buzzer);
    endtask

    task automatic test_snooze();
        fire();
        snooze_btn = 1'b1; cyc(); snooze_btn = 1'b0;
        n_checks++;
        if (state !== 2'd3 || snooze_count !== 4'd1 || snoozing !== 1'b1 || buzzer !== 1'b0) begin
            n_fails++;
            $display("FAIL snooze1: got st=%0d cnt=%0d sz=%0d bz=%0d want st=3 cnt=1 sz=1 bz=0",
                     state, snooze_count, snoozing, buzzer);
        end
        tick(); tick();
        n_checks++;
        if (state !== 2'd3) begin n_fails++; $display("FAIL snooze_hold: got %0d want 3", state); end
        tick();
        n_checks++;
        if (state !== 2'd2 || buzzer !== 1'b1) begin
            n_fails++; $display("FAIL rering1: got st=%0d bz=%0d want st=2 bz=1", state, buzzer);
        end
        snooze_btn = 1'b1; cyc(); snooze_btn = 1'b0;
        n_checks++;
        if (state !== 2'd3 || snooze_count !== 4'd2) begin
            n_fails++; $display("FAIL snooze2: got st=%0d cnt=%0d want st=3 cnt=2", state, snooze_count);
        end
        tick(); tick(); tick();
        snooze_btn = 1'b1; cyc(); snooze_btn = 1'b0; cyc();
        n_checks++;
        if (state !== 2'd2 || snooze_count !== 4'd2) begin
            n_fails++; $display("FAIL snooze_limit: got st=%0d cnt=%0d want st=2 cnt=2", state, snooze_count);
        end
        stop_btn = 1'b1; cyc(); stop_btn = 1'b0; cyc();
        n_checks++;
        if (state !== 2'd1 || snooze_count !== 4'd2) begin
            n_fails++; $display("FAIL stop_hold_cnt: got st=%0d cnt=%0d want st=1 cnt=2", state, snooze_count);
        end
        $display("snooze: state=%0d snooze_count=%0d", state, snooze_count);
    endtask

    task automatic test_stop_vs_snooze();
        fire();
        n_checks++;
        if (state !== 2'd2 || snooze_count !== 4'd0) begin
            n_fails++; $display("FAIL retrigger: got st=%0d cnt=%0d want st=2 cnt=0", state, snooze_count);
        end
        stop_btn = 1'b1; snooze_btn = 1'b1; cyc();
        n_checks++;
        if (state !== 2'd1 || snooze_count !== 4'd0) begin
            n_fails++; $display("FAIL stop_wins: got st=%0d cnt=%0d want st=1 cnt=0", state, snooze_count);
        end
        snooze_btn = 1'b0;
        cyc();
        fire();
        repeat (10) cyc();
        n_checks++;
        if (state !== 2'd2) begin n_fails++; $display("FAIL held_stop: got %0d want 2", state); end
        stop_btn = 1'b0; cyc();
        stop_btn = 1'b1; cyc(); stop_btn = 1'b0;
        n_checks++;
        if (state !== 2'd1) begin n_fails++; $display("FAIL second_stop: got %0d want 1", state); end
        $display("stop_vs_snooze: state=%0d", state);
    endtask

    task automatic test_alarm_mode();
        set_cur(7, 29, 59); cyc();
        alarm_mode = 1'b1;
        set_cur(7, 30, 0); repeat (3) cyc();
        n_checks++;
        if (state !== 2'd1 || ringing !== 1'b0) begin
            n_fails++; $display("FAIL mode_suppress: got st=%0d rg=%0d want st=1 rg=0", state, ringing);
        end
        alarm_mode = 1'b0; repeat (3) cyc();
        n_checks++;
        if (state !== 2'd1 || ringing !== 1'b0) begin
            n_fails++; $display("FAIL mode_exit: got st=%0d rg=%0d want st=1 rg=0", state, ringing);
        end
        $display("alarm_mode: state=%0d", state);
    endtask

    task automatic test_disable_reset();
        fire();
        snooze_btn = 1'b1; cyc(); snooze_btn = 1'b0;
        alarm_enable = 1'b0; cyc();
        n_checks++;
        if (state !== 2'd0 || snooze_count !== 4'd0 || snoozing !== 1'b0) begin
            n_fails++; $display("FAIL disable: got st=%0d cnt=%0d sz=%0d want 0 0 0", state, snooze_count, snoozing);
        end
        alarm_enable = 1'b1; cyc();
        n_checks++;
        if (state !== 2'd1) begin n_fails++; $display("FAIL rearm: got %0d want 1", state); end
        fire();
        reset = 1'b1; cyc(); reset = 1'b0;
        n_checks++;
        if ({state, buzzer, ringing, snoozing, snooze_count} !== 9'd0) begin
            n_fails++;
            $display("FAIL reset_ring: got st=%0d bz=%0d rg=%0d sz=%0d cnt=%0d want all 0",
                     state, buzzer, ringing, snoozing, snooze_count);
        end
        cyc();
        n_checks++;
        if (state !== 2'd1) begin n_fails++; $display("FAIL post_reset_arm: got %0d want 1", state); end
        $display("disable_reset: state=%0d", state);
    endtask

    task automatic test_random();
        int r;
        bit [1:0] e_state;
        bit e_buz;
        for (int i = 0; i < 3000; i++) begin
            e_state = 2'(m_phase);
            e_buz   = (m_phase == 2) && m_beep;
            n_checks++;
            if (state !== e_state || buzzer !== e_buz || ringing !== (m_phase == 2)
                || snoozing !== (m_phase == 3) || snooze_count !== 4'(m_used)) begin
                n_fails++;
                $display("FAIL random[%0d]: got st=%0d bz=%0d rg=%0d sz=%0d cnt=%0d want st=%0d bz=%0d cnt=%0d",
                         i, state, buzzer, ringing, snoozing, snooze_count, e_state, e_buz, m_used);
            end
            r = int'($urandom_range(0, 9));
            if (r < 5)      set_cur(7, 30, 0);
            else if (r < 9) set_cur(7, 29, 59);
            else            set_cur(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)),
                                    int'($urandom_range(0, 59)));
            reset        = ($urandom_range(0, 199) == 0);
            alarm_enable = ($urandom_range(0, 59) != 0);
            alarm_mode   = ($urandom_range(0, 19) == 0);
            tick_1hz     = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 7) == 0) snooze_btn = ~snooze_btn;
            if ($urandom_range(0, 11) == 0) stop_btn = ~stop_btn;
            cyc();
        end
        $display("random: 3000 cycles compared against model");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc();
        test_reset();
        test_trigger();
        test_timeout();
        test_snooze();
        test_stop_vs_snooze();
        test_alarm_mode();
        test_disable_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
